// File: rtl/vip_csc_pkg.sv
// Shared types and constants for vip_color_space_converter.
// Holds both coefficient sets; the top selects one with VIP_CSC_LIMITED_RANGE_EN.
package vip_csc_pkg;

    typedef enum logic [1:0] {
        CSC_YCBCR  = 2'd0,
        CSC_GREY   = 2'd1,
        CSC_BYPASS = 2'd2
    } csc_mode_e;

    localparam int CSC_LATENCY = 3;
    localparam int CSC_SHIFT   = 8;
    localparam int CSC_ROUND   = 128;

    // Full-range coefficients in Q8, rows Y/Cb/Cr, columns R/G/B
    localparam int FR_Y_R  = 77;
    localparam int FR_Y_G  = 150;
    localparam int FR_Y_B  = 29;
    localparam int FR_CB_R = -43;
    localparam int FR_CB_G = -85;
    localparam int FR_CB_B = 128;
    localparam int FR_CR_R = 128;
    localparam int FR_CR_G = -107;
    localparam int FR_CR_B = -21;

    // BT.601 limited-range coefficients in Q8
    localparam int LR_Y_R  = 66;
    localparam int LR_Y_G  = 129;
    localparam int LR_Y_B  = 25;
    localparam int LR_CB_R = -38;
    localparam int LR_CB_G = -74;
    localparam int LR_CB_B = 112;
    localparam int LR_CR_R = 112;
    localparam int LR_CR_G = -94;
    localparam int LR_CR_B = -18;

    function automatic int csc_coef(input bit limited, input int idx);
        case (idx)
            0:       return limited ? LR_Y_R  : FR_Y_R;
            1:       return limited ? LR_Y_G  : FR_Y_G;
            2:       return limited ? LR_Y_B  : FR_Y_B;
            3:       return limited ? LR_CB_R : FR_CB_R;
            4:       return limited ? LR_CB_G : FR_CB_G;
            5:       return limited ? LR_CB_B : FR_CB_B;
            6:       return limited ? LR_CR_R : FR_CR_R;
            7:       return limited ? LR_CR_G : FR_CR_G;
            8:       return limited ? LR_CR_B : FR_CR_B;
            default: return 0;
        endcase
    endfunction

    // Encodings 2 and 3 both mean bypass
    function automatic csc_mode_e csc_decode(input logic [1:0] mode);
        case (mode)
            2'd0:    return CSC_YCBCR;
            2'd1:    return CSC_GREY;
            default: return CSC_BYPASS;
        endcase
    endfunction

endpackage

// File: rtl/vip_sync_delay.sv
// Fixed-depth shift register that keeps frame qualifiers aligned with the pixel pipeline.
module vip_sync_delay
    import vip_csc_pkg::*;
#(
    parameter int DEPTH = CSC_LATENCY,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_shift [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_shift[i] <= '0;
        end else begin
            r_shift[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) r_shift[i] <= r_shift[i-1];
        end
    end

    assign o_data = r_shift[DEPTH-1];

endmodule

// File: rtl/vip_color_space_converter.sv
// RGB to YCbCr / grey / bypass converter: 3-stage pipeline with delayed frame qualifiers.
// Define VIP_CSC_LIMITED_RANGE_EN for BT.601 limited range; the default build is full range.
module vip_color_space_converter
    import vip_csc_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        cfg_mode,
    input  logic              per_frame_vsync,
    input  logic              per_frame_href,
    input  logic              per_frame_clken,
    input  logic [DATA_W-1:0] per_img_red,
    input  logic [DATA_W-1:0] per_img_green,
    input  logic [DATA_W-1:0] per_img_blue,
    output logic              post_frame_vsync,
    output logic              post_frame_href,
    output logic              post_frame_clken,
    output logic [DATA_W-1:0] post_img_Y,
    output logic [DATA_W-1:0] post_img_Cb,
    output logic [DATA_W-1:0] post_img_Cr,
    output logic [1:0]        mode_active
);

    localparam int SUM_W = DATA_W + 10;
    typedef logic signed [SUM_W-1:0] sum_t;

`ifdef VIP_CSC_LIMITED_RANGE_EN
    localparam bit   LIMITED_EN = 1'b1;
    localparam sum_t OFF_Y      = sum_t'(16 * 2**DATA_W);
    localparam sum_t Y_LO       = sum_t'(16 * 2**(DATA_W-8));
    localparam sum_t Y_HI       = sum_t'(235 * 2**(DATA_W-8));
    localparam sum_t C_LO       = sum_t'(16 * 2**(DATA_W-8));
    localparam sum_t C_HI       = sum_t'(240 * 2**(DATA_W-8));
`else
    localparam bit   LIMITED_EN = 1'b0;
    localparam sum_t OFF_Y      = sum_t'(0);
    localparam sum_t Y_LO       = sum_t'(0);
    localparam sum_t Y_HI       = sum_t'(2**DATA_W - 1);
    localparam sum_t C_LO       = sum_t'(0);
    localparam sum_t C_HI       = sum_t'(2**DATA_W - 1);
`endif
    localparam sum_t              OFF_C = sum_t'(2**(DATA_W+7));
    localparam sum_t              RND   = sum_t'(CSC_ROUND);
    localparam logic [DATA_W-1:0] MID   = DATA_W'(2**(DATA_W-1));

    function automatic logic [DATA_W-1:0] clamp(input sum_t v, input sum_t lo, input sum_t hi);
        if (v < lo) return lo[DATA_W-1:0];
        if (v > hi) return hi[DATA_W-1:0];
        return v[DATA_W-1:0];
    endfunction

    logic                r_vsync_d;
    logic [1:0]          r_mode_active;
    logic                w_vsync_rise;
    logic [1:0]          w_pix_mode;
    sum_t                w_pix [3];
    sum_t                r_prod [9];
    sum_t                r_sum [3];
    sum_t                w_shift [3];
    logic [1:0]          r_mode_s1;
    logic [1:0]          r_mode_s2;
    logic [3*DATA_W-1:0] r_byp_s1;
    logic [3*DATA_W-1:0] r_byp_s2;
    logic [DATA_W-1:0]   w_y;
    logic [DATA_W-1:0]   w_cb;
    logic [DATA_W-1:0]   w_cr;
    logic [DATA_W-1:0]   r_y;
    logic [DATA_W-1:0]   r_cb;
    logic [DATA_W-1:0]   r_cr;
    logic [2:0]          w_sync_out;

    assign w_vsync_rise = per_frame_vsync & ~r_vsync_d;
    // A pixel arriving with the vsync edge already takes the newly loaded mode
    assign w_pix_mode   = w_vsync_rise ? cfg_mode : r_mode_active;

    assign w_pix[0] = sum_t'(per_img_red);
    assign w_pix[1] = sum_t'(per_img_green);
    assign w_pix[2] = sum_t'(per_img_blue);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vsync_d     <= 1'b0;
            r_mode_active <= 2'd0;
        end else begin
            r_vsync_d <= per_frame_vsync;
            if (w_vsync_rise) r_mode_active <= cfg_mode;
        end
    end

    // The mode and raw pixel travel with the data so each pixel keeps its own mode
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 9; i++) r_prod[i] <= '0;
            for (int i = 0; i < 3; i++) r_sum[i] <= '0;
            r_mode_s1 <= 2'd0;
            r_mode_s2 <= 2'd0;
            r_byp_s1  <= '0;
            r_byp_s2  <= '0;
            r_y       <= '0;
            r_cb      <= '0;
            r_cr      <= '0;
        end else begin
            for (int i = 0; i < 3; i++)
                for (int k = 0; k < 3; k++)
                    r_prod[3*i+k] <= w_pix[k] * sum_t'(csc_coef(LIMITED_EN, 3*i+k));
            r_mode_s1 <= w_pix_mode;
            r_byp_s1  <= {per_img_red, per_img_green, per_img_blue};

            for (int i = 0; i < 3; i++)
                r_sum[i] <= r_prod[3*i] + r_prod[3*i+1] + r_prod[3*i+2]
                          + ((i == 0) ? OFF_Y : OFF_C) + RND;
            r_mode_s2 <= r_mode_s1;
            r_byp_s2  <= r_byp_s1;

            r_y  <= w_y;
            r_cb <= w_cb;
            r_cr <= w_cr;
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) w_shift[i] = r_sum[i] >>> CSC_SHIFT;
        w_y  = clamp(w_shift[0], Y_LO, Y_HI);
        w_cb = clamp(w_shift[1], C_LO, C_HI);
        w_cr = clamp(w_shift[2], C_LO, C_HI);
        case (csc_decode(r_mode_s2))
            CSC_GREY: begin
                w_cb = MID;
                w_cr = MID;
            end
            CSC_BYPASS: begin
                w_y  = r_byp_s2[3*DATA_W-1 -: DATA_W];
                w_cb = r_byp_s2[2*DATA_W-1 -: DATA_W];
                w_cr = r_byp_s2[DATA_W-1:0];
            end
            default: ;
        endcase
    end

    vip_sync_delay #(
        .DEPTH (CSC_LATENCY),
        .WIDTH (3)
    ) u_sync_delay (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_data ({per_frame_vsync, per_frame_href, per_frame_clken}),
        .o_data (w_sync_out)
    );

    assign {post_frame_vsync, post_frame_href, post_frame_clken} = w_sync_out;
    assign post_img_Y  = r_y;
    assign post_img_Cb = r_cb;
    assign post_img_Cr = r_cr;
    assign mode_active = r_mode_active;

endmodule

// File: tb/tb_vip_color_space_converter.sv
// Directed, table-driven bench for vip_color_space_converter (DATA_W = 8).
// Expected values follow VIP_CSC_LIMITED_RANGE_EN when the bench is built with it.
module tb_vip_color_space_converter;

    localparam int DATA_W = 8;

`ifdef VIP_CSC_LIMITED_RANGE_EN
    localparam int WHITE_Y = 235, WHITE_CB = 128, WHITE_CR = 128;
    localparam int RED_Y   = 82,  RED_CB   = 90,  RED_CR   = 240;
    localparam int ZERO_Y  = 16;
`else
    localparam int WHITE_Y = 255, WHITE_CB = 128, WHITE_CR = 128;
    localparam int RED_Y   = 77,  RED_CB   = 85,  RED_CR   = 255;
    localparam int ZERO_Y  = 0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        cfg_mode;
    logic              per_frame_vsync;
    logic              per_frame_href;
    logic              per_frame_clken;
    logic [DATA_W-1:0] per_img_red;
    logic [DATA_W-1:0] per_img_green;
    logic [DATA_W-1:0] per_img_blue;
    logic              post_frame_vsync;
    logic              post_frame_href;
    logic              post_frame_clken;
    logic [DATA_W-1:0] post_img_Y;
    logic [DATA_W-1:0] post_img_Cb;
    logic [DATA_W-1:0] post_img_Cr;
    logic [1:0]        mode_active;

    vip_color_space_converter #(.DATA_W(DATA_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cfg_mode         (cfg_mode),
        .per_frame_vsync  (per_frame_vsync),
        .per_frame_href   (per_frame_href),
        .per_frame_clken  (per_frame_clken),
        .per_img_red      (per_img_red),
        .per_img_green    (per_img_green),
        .per_img_blue     (per_img_blue),
        .post_frame_vsync (post_frame_vsync),
        .post_frame_href  (post_frame_href),
        .post_frame_clken (post_frame_clken),
        .post_img_Y       (post_img_Y),
        .post_img_Cb      (post_img_Cb),
        .post_img_Cr      (post_img_Cr),
        .mode_active      (mode_active)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] mode;
        logic [7:0] r, g, b;
        logic [7:0] y, cb, cr;
    } vec_t;

    vec_t vecs[$];
    vec_t stream[$];
    int   total = 0;
    int   bad   = 0;

    function automatic void addVec(input logic [1:0] m, input int r, input int g, input int b,
                                   input int y, input int cb, input int cr);
        vec_t v;
        v.mode = m;
        v.r = 8'(r); v.g = 8'(g); v.b = 8'(b);
        v.y = 8'(y); v.cb = 8'(cb); v.cr = 8'(cr);
        vecs.push_back(v);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                                 input logic clken, input logic href, input logic vsync);
        per_img_red     = r;
        per_img_green   = g;
        per_img_blue    = b;
        per_frame_clken = clken;
        per_frame_href  = href;
        per_frame_vsync = vsync;
    endtask

    // One vsync pulse with no pixel; the mode must be loaded on that edge
    task automatic frameStart(input logic [1:0] m);
        cfg_mode = m;
        applyStimulus(0, 0, 0, 0, 0, 1);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("frame mode_active", 32'(mode_active), 32'(m));
    endtask

    // Single pixel followed by a blank; result must show up on exactly the third edge
    task automatic runPixel(input string tag, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                            input logic vs, input logic [1:0] emode,
                            input int ey, input int ecb, input int ecr);
        applyStimulus(r, g, b, 1, 1, vs);
        @(negedge clk);
        checkOutput({tag, " mode_active"}, 32'(mode_active), 32'(emode));
        applyStimulus(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput({tag, " early clken"}, 32'(post_frame_clken), 0);
        @(negedge clk);
        checkOutput({tag, " Y"}, 32'(post_img_Y), 32'(ey));
        checkOutput({tag, " Cb"}, 32'(post_img_Cb), 32'(ecb));
        checkOutput({tag, " Cr"}, 32'(post_img_Cr), 32'(ecr));
        checkOutput({tag, " clken"}, 32'(post_frame_clken), 1);
        checkOutput({tag, " href"}, 32'(post_frame_href), 1);
        checkOutput({tag, " vsync"}, 32'(post_frame_vsync), 32'(vs));
        @(negedge clk);
        checkOutput({tag, " late clken"}, 32'(post_frame_clken), 0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
`ifdef VIP_CSC_LIMITED_RANGE_EN
        addVec(2'd0, 255, 255, 255, 235, 128, 128);
        addVec(2'd0,   0,   0,   0,  16, 128, 128);
        addVec(2'd0, 255,   0,   0,  82,  90, 240);
        addVec(2'd0,   0,   0, 255,  41, 240, 110);
        addVec(2'd1, 255,   0,   0,  82, 128, 128);
`else
        addVec(2'd0, 255, 255, 255, 255, 128, 128);
        addVec(2'd0, 255,   0,   0,  77,  85, 255);
        addVec(2'd0,   0,   0, 255,  29, 255, 107);
        addVec(2'd0,   0,   0,   0,   0, 128, 128);
        addVec(2'd0,   0, 255,   0, 149,  43,  21);
        addVec(2'd0, 100, 150, 200, 141, 161,  99);
        addVec(2'd1, 255,   0,   0,  77, 128, 128);
`endif
        addVec(2'd2,  10,  20,  30,  10,  20,  30);
        addVec(2'd3, 200, 100,  50, 200, 100,  50);

        rst_n    = 1'b0;
        cfg_mode = 2'd0;
        applyStimulus(0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        checkOutput("reset Y", 32'(post_img_Y), 0);
        checkOutput("reset Cb", 32'(post_img_Cb), 0);
        checkOutput("reset Cr", 32'(post_img_Cr), 0);
        checkOutput("reset clken", 32'(post_frame_clken), 0);
        checkOutput("reset href", 32'(post_frame_href), 0);
        checkOutput("reset vsync", 32'(post_frame_vsync), 0);
        checkOutput("reset mode_active", 32'(mode_active), 0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            frameStart(vecs[i].mode);
            runPixel($sformatf("vec%0d", i), vecs[i].r, vecs[i].g, vecs[i].b, 1'b0,
                     vecs[i].mode, vecs[i].y, vecs[i].cb, vecs[i].cr);
        end

        // Back-to-back pixels: each must come out untouched by its neighbours
        foreach (vecs[i]) if (vecs[i].mode == 2'd0) stream.push_back(vecs[i]);
        frameStart(2'd0);
        for (int c = 0; c < stream.size() + 2; c++) begin
            if (c < stream.size()) applyStimulus(stream[c].r, stream[c].g, stream[c].b, 1, 1, 0);
            else applyStimulus(0, 0, 0, 0, 0, 0);
            @(negedge clk);
            if (c >= 2) begin
                checkOutput($sformatf("stream%0d Y", c-2), 32'(post_img_Y), 32'(stream[c-2].y));
                checkOutput($sformatf("stream%0d Cb", c-2), 32'(post_img_Cb), 32'(stream[c-2].cb));
                checkOutput($sformatf("stream%0d Cr", c-2), 32'(post_img_Cr), 32'(stream[c-2].cr));
            end
        end
        applyStimulus(0, 0, 0, 0, 0, 0);
        @(negedge clk);

        // Mode request mid-frame is ignored until the next vsync edge
        cfg_mode = 2'd1;
        runPixel("midframe", 255, 0, 0, 1'b0, 2'd0, RED_Y, RED_CB, RED_CR);
        frameStart(2'd1);
        runPixel("grey after vsync", 255, 0, 0, 1'b0, 2'd1, RED_Y, 128, 128);

        cfg_mode = 2'd2;
        runPixel("vsync with pixel", 10, 20, 30, 1'b1, 2'd2, 10, 20, 30);

        // One-cycle reset mid-line must flush everything in flight
        frameStart(2'd1);
        applyStimulus(255, 255, 255, 1, 1, 0);
        @(negedge clk);
        rst_n = 1'b0;
        applyStimulus(255, 0, 0, 1, 1, 0);
        @(negedge clk);
        checkOutput("midreset Y", 32'(post_img_Y), 0);
        checkOutput("midreset Cb", 32'(post_img_Cb), 0);
        checkOutput("midreset Cr", 32'(post_img_Cr), 0);
        checkOutput("midreset clken", 32'(post_frame_clken), 0);
        checkOutput("midreset href", 32'(post_frame_href), 0);
        checkOutput("midreset vsync", 32'(post_frame_vsync), 0);
        checkOutput("midreset mode_active", 32'(mode_active), 0);
        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            checkOutput($sformatf("flush%0d clken", c), 32'(post_frame_clken), 0);
            checkOutput($sformatf("flush%0d href", c), 32'(post_frame_href), 0);
            checkOutput($sformatf("flush%0d Y", c), 32'(post_img_Y), 32'(ZERO_Y));
        end

        frameStart(2'd0);
        runPixel("after reset", 255, 255, 255, 1'b0, 2'd0, WHITE_Y, WHITE_CB, WHITE_CR);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
